// File: rtl/fixed_pkg.sv
// Shared definitions for the fixed-point arithmetic family (multiplier, and
// later the adder and MAC).
//   round_mode_t   : encoding of the ROUND parameter (text constant)
//   ROUND_TRUNC    : floor toward -inf
//   ROUND_NEAREST  : round half toward +inf
//   sat_limits_t   : signed min/max of a two's complement word
//   sat_bits(w)    : returns the min/max limits for a w-bit word (w <= 63)
package fixed_pkg;

  typedef logic [55:0] round_mode_t;

  localparam round_mode_t ROUND_TRUNC   = round_mode_t'("TRUNC");
  localparam round_mode_t ROUND_NEAREST = round_mode_t'("NEAREST");

  typedef struct packed {
    logic signed [63:0] min_v;
    logic signed [63:0] max_v;
  } sat_limits_t;

  function automatic sat_limits_t sat_bits(input int width);
    sat_limits_t lim;
    lim.max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    lim.min_v = -(64'sd1 <<< (width - 1));
    return lim;
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational rounding, range check and optional clamp of a full-width
// signed product down to a Q(BITS-FRACTION).FRACTION word.
//   p        : in  2*BITS signed full-precision value (product)
//   c        : out BITS   rounded (and clamped or wrapped) result
//   overflow : out 1      rounded value lies outside the BITS-bit range
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int          BITS     = 8,
  parameter int          FRACTION = 4,
  parameter round_mode_t ROUND    = ROUND_TRUNC,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [2*BITS-1:0] p,
  output logic [BITS-1:0]   c,
  output logic              overflow
);

  // One guard bit above the product so adding the rounding constant to the
  // most positive product cannot wrap.
  localparam int          RW      = 2 * BITS + 1;
  localparam bit          NEAREST = (ROUND == ROUND_NEAREST);
  localparam sat_limits_t LIM     = sat_bits(BITS);

  localparam logic signed [RW-1:0] MAX_R = RW'($signed(LIM.max_v));
  localparam logic signed [RW-1:0] MIN_R = RW'($signed(LIM.min_v));
  // 2^(FRACTION-1); written as (1<<F)>>1 so FRACTION=0 yields 0 rather than
  // a negative shift.
  localparam logic signed [RW-1:0] HALF  = NEAREST ? ((RW'(1) << FRACTION) >> 1) : '0;

  logic signed [RW-1:0] p_ext;
  logic signed [RW-1:0] r;

  always_comb begin
    p_ext = RW'($signed(p));
    if (NEAREST) begin
      r = (p_ext + HALF) >>> FRACTION;
    end else begin
      r = p_ext >>> FRACTION;
    end

    overflow = (r > MAX_R) || (r < MIN_R);

    if (SATURATE && (r > MAX_R)) begin
      c = MAX_R[BITS-1:0];
    end else if (SATURATE && (r < MIN_R)) begin
      c = MIN_R[BITS-1:0];
    end else begin
      c = r[BITS-1:0];
    end
  end

endmodule

// File: rtl/fixed_multiply_pipe.sv
// Pipelined signed fixed-point multiplier with rounding, saturation and
// overflow flag, valid/ready on both sides with full backpressure.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   in_valid   : in  operands a/b present
//   in_ready   : out block accepts operands this cycle
//   a, b       : in  BITS signed operands
//   out_valid  : out result present
//   out_ready  : in  consumer accepts result this cycle
//   c          : out BITS signed result
//   overflow   : out result exceeded range (qualified by out_valid)
//
// Handshake: a word transfers on a rising edge where valid and ready are
// both high. The producer holds its payload while valid&~ready; ready may
// depend on the consumer's ready combinationally but never on valid.
//
// Stage 1 holds the exact product, stages 2..STAGES-1 delay it, and stage
// STAGES holds the rounded/clamped result. A stage loads when it, or any
// stage after it, is empty, or when the output is being consumed, so
// bubbles collapse and a full pipe still streams 1 word per cycle.
module fixed_multiply_pipe
  import fixed_pkg::*;
#(
  parameter int          BITS     = 8,
  parameter int          FRACTION = 4,
  parameter int          STAGES   = 3,
  parameter round_mode_t ROUND    = ROUND_TRUNC,
  parameter bit          SATURATE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] c,
  output logic            overflow
);

  localparam int PW = 2 * BITS;

  if (BITS < 2 || BITS > 32) begin : g_bad_bits
    $error("fixed_multiply_pipe: BITS must be in 2..32");
  end
  if (FRACTION < 0 || FRACTION > BITS - 1) begin : g_bad_fraction
    $error("fixed_multiply_pipe: FRACTION must be in 0..BITS-1");
  end
  if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
    $error("fixed_multiply_pipe: STAGES must be in 2..8");
  end
  if (ROUND != ROUND_TRUNC && ROUND != ROUND_NEAREST) begin : g_bad_round
    $error("fixed_multiply_pipe: ROUND must be TRUNC or NEAREST");
  end
  if (ROUND == ROUND_NEAREST && FRACTION < 1) begin : g_bad_nearest
    $error("fixed_multiply_pipe: NEAREST rounding needs FRACTION >= 1");
  end

  logic [STAGES:1] valid;
  logic [STAGES:1] load;
  logic [PW-1:0]   prod_q [1:STAGES-1];
  logic [PW-1:0]   prod_d;
  logic [BITS-1:0] c_d;
  logic            overflow_d;

  // load[k] is true when some stage at or after k is empty, or the output
  // is draining; built back-to-front with a running "hole" flag.
  always_comb begin : load_chain
    logic hole;
    hole = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      hole    = hole | ~valid[k];
      load[k] = hole;
    end
  end

  assign in_ready  = load[1] & ~reset;
  assign out_valid = valid[STAGES];

  always_comb begin
    prod_d = PW'($signed(a)) * PW'($signed(b));
  end

  fixed_round_sat #(
    .BITS     (BITS),
    .FRACTION (FRACTION),
    .ROUND    (ROUND),
    .SATURATE (SATURATE)
  ) u_round_sat (
    .p        (prod_q[STAGES-1]),
    .c        (c_d),
    .overflow (overflow_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= '0;
      c        <= '0;
      overflow <= 1'b0;
      for (int k = 1; k <= STAGES - 1; k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      if (load[1]) begin
        valid[1]  <= in_valid;
        prod_q[1] <= prod_d;
      end
      for (int k = 2; k <= STAGES - 1; k++) begin
        if (load[k]) begin
          valid[k]  <= valid[k-1];
          prod_q[k] <= prod_q[k-1];
        end
      end
      if (load[STAGES]) begin
        valid[STAGES] <= valid[STAGES-1];
        c             <= c_d;
        overflow      <= overflow_d;
      end
    end
  end

endmodule

// File: tb/tb_fixed_multiply_pipe.sv
// Bench for fixed_multiply_pipe: seven instances (BITS=8, FRACTION=4) with
// different STAGES / ROUND / SATURATE settings, a per-instance expected
// queue filled at input acceptance and drained by a monitor at output
// transfer, plus directed latency, backpressure and reset checks.
module tb_fixed_multiply_pipe;
  import fixed_pkg::*;

  localparam int NDUT = 7;
  //                               0  1  2  3  4  5  6
  localparam int ST [NDUT] = '{3, 3, 3, 2, 8, 2, 8};
  localparam bit NR [NDUT] = '{0, 1, 0, 1, 0, 0, 1};
  localparam bit SA [NDUT] = '{1, 1, 0, 1, 0, 1, 0};

  logic                clk;
  logic                reset;
  logic [NDUT-1:0]     in_valid;
  logic [NDUT-1:0]     in_ready;
  logic [NDUT-1:0]     out_valid;
  logic [NDUT-1:0]     out_ready;
  logic [NDUT-1:0]     ovf_s;
  logic [7:0]          a_s   [NDUT];
  logic [7:0]          b_s   [NDUT];
  logic [7:0]          c_s   [NDUT];
  logic [8:0]          exp_in[NDUT];

  logic [8:0]          exp_q [NDUT][$];
  int                  out_cnt [NDUT];
  int                  checks;
  int                  failures;

  // ---------------- clock / instances ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fixed_multiply_pipe #(
      .BITS     (8),
      .FRACTION (4),
      .STAGES   (ST[g]),
      .ROUND    (NR[g] ? ROUND_NEAREST : ROUND_TRUNC),
      .SATURATE (SA[g])
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a_s[g]),
      .b         (b_s[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .c         (c_s[g]),
      .overflow  (ovf_s[g])
    );
  end

  // ---------------- reference model: returns {overflow, c} ----------------
  function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input bit nr, input bit sat);
    longint     p;
    longint     r;
    logic       ov;
    logic [7:0] cv;
    p = longint'($signed(av)) * longint'($signed(bv));
    if (nr) p = p + 8;
    r  = p >>> 4;
    ov = (r > 127) || (r < -128);
    if (sat && r > 127) cv = 8'h7F;
    else if (sat && r < -128) cv = 8'h80;
    else cv = r[7:0];
    return {ov, cv};
  endfunction

  task automatic check(input string name, input int idx, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, idx, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor_loop();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (reset) begin
          exp_q[i].delete();
        end else begin
          if (in_valid[i] && in_ready[i]) exp_q[i].push_back(exp_in[i]);
          if (out_valid[i] && out_ready[i]) begin
            out_cnt[i]++;
            if (exp_q[i].size() == 0) begin
              check("unexpected_output", i, {ovf_s[i], c_s[i]}, 9'h1FF + 1);
            end else begin
              e = exp_q[i].pop_front();
              check("result", i, {ovf_s[i], c_s[i]}, e);
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one operand pair and hold it until accepted; returns just after
  // the accepting edge.
  task automatic send(input int i, input logic [7:0] av, input logic [7:0] bv,
                      input logic [8:0] ev);
    int n;
    in_valid[i] = 1'b1;
    a_s[i]      = av;
    b_s[i]      = bv;
    exp_in[i]   = ev;
    n = 0;
    @(negedge clk);
    while (!in_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[i]) check("send_timeout", i, 0, 1);
    tick();
    in_valid[i] = 1'b0;
  endtask

  task automatic lat_check(input int i, input logic [7:0] av, input logic [7:0] bv,
                           input logic [8:0] ev, input int exp_lat);
    int n;
    send(i, av, bv, ev);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid[i] && n < 40);
    check("latency", i, n, exp_lat);
    tick();
  endtask

  task automatic run_backpressure();
    int idx;
    int acc_stall;
    int base;
    idx       = 0;
    acc_stall = 0;
    base      = out_cnt[0];
    for (int k = 0; k < 80; k++) begin
      out_ready[0] = !(k >= 4 && k <= 9);
      in_valid[0]  = (k >= 4) && (idx < 10);
      if (idx < 10) begin
        a_s[0]    = 8'h20;
        b_s[0]    = 8'(idx + 1);
        exp_in[0] = {1'b0, 8'(2 * (idx + 1))};
      end
      @(negedge clk);
      if (k >= 7 && k <= 9) begin
        check("stall_in_ready", 0, in_ready[0], 0);
        check("stall_out_valid", 0, out_valid[0], 1);
        check("stall_c_stable", 0, c_s[0], 8'h02);
      end
      if (k == 10) check("full_stream_in_ready", 0, in_ready[0], 1);
      if (in_valid[0] && in_ready[0]) begin
        if (k >= 4 && k <= 9) acc_stall++;
        idx++;
      end
      tick();
      if (idx == 10 && (out_cnt[0] - base) == 10) break;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    check("stall_accepts", 0, acc_stall, 3);
    check("bp_outputs", 0, out_cnt[0] - base, 10);
  endtask

  task automatic run_random();
    bit acc [NDUT];
    for (int i = 0; i < NDUT; i++) acc[i] = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 3; i < NDUT; i++) begin
        if (!in_valid[i] || acc[i]) begin
          in_valid[i] = 1'($urandom_range(0, 1));
          a_s[i]      = 8'($urandom_range(0, 255));
          b_s[i]      = 8'($urandom_range(0, 255));
          exp_in[i]   = model(a_s[i], b_s[i], NR[i], SA[i]);
        end
        out_ready[i] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      for (int i = 3; i < NDUT; i++) acc[i] = in_valid[i] && in_ready[i];
      tick();
    end
    for (int i = 3; i < NDUT; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (20) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    in_valid = '0;
    out_ready = '1;
    for (int i = 0; i < NDUT; i++) begin
      a_s[i]     = '0;
      b_s[i]     = '0;
      exp_in[i]  = '0;
      out_cnt[i] = 0;
    end

    fork
      monitor_loop();
    join_none

    // reset state
    tick();
    tick();
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) check("reset_in_ready", i, in_ready[i], 0);
    tick();
    for (int i = 0; i < NDUT; i++) begin
      check("reset_out_valid", i, out_valid[i], 0);
      check("reset_c", i, c_s[i], 0);
      check("reset_overflow", i, ovf_s[i], 0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) check("post_reset_in_ready", i, in_ready[i], 1);
    tick();

    // latency equals STAGES: 1.5 * 2.0 = 3.0
    lat_check(0, 8'h18, 8'h20, 9'h030, 3);
    lat_check(3, 8'h18, 8'h20, 9'h030, 2);
    lat_check(4, 8'h18, 8'h20, 9'h030, 8);

    // directed values, TRUNC + saturate
    send(0, 8'h40, 8'h40, 9'h17F);
    send(0, 8'h80, 8'h80, 9'h17F);
    send(0, 8'h80, 8'h40, 9'h180);
    send(0, 8'h7F, 8'h10, 9'h07F);
    send(0, 8'h80, 8'h10, 9'h080);
    send(0, 8'h01, 8'h08, 9'h000);
    send(0, 8'hFF, 8'h08, 9'h0FF);
    send(0, 8'h03, 8'h08, 9'h001);
    send(0, 8'hF0, 8'h18, 9'h0E8);
    // NEAREST + saturate
    send(1, 8'h01, 8'h08, 9'h001);
    send(1, 8'hFF, 8'h08, 9'h000);
    send(1, 8'h03, 8'h08, 9'h002);
    send(1, 8'h40, 8'h40, 9'h17F);
    // TRUNC + wrap
    send(2, 8'h40, 8'h40, 9'h100);
    send(2, 8'h80, 8'h80, 9'h100);
    send(2, 8'h80, 8'h40, 9'h100);
    send(2, 8'h7F, 8'h7F, 9'h1F0);
    send(2, 8'hFF, 8'h08, 9'h0FF);
    repeat (12) tick();

    // backpressure on the STAGES=3 instance
    run_backpressure();
    repeat (6) tick();

    // reset with three items in flight
    out_ready[0] = 1'b0;
    send(0, 8'h20, 8'h01, 9'h002);
    send(0, 8'h20, 8'h02, 9'h004);
    send(0, 8'h20, 8'h03, 9'h006);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", 0, in_ready[0], 0);
    tick();
    check("midreset_out_valid", 0, out_valid[0], 0);
    check("midreset_c", 0, c_s[0], 0);
    check("midreset_overflow", 0, ovf_s[0], 0);
    reset        = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("midreset_release_in_ready", 0, in_ready[0], 1);
    tick();
    begin
      int base;
      base = out_cnt[0];
      lat_check(0, 8'h30, 8'h10, 9'h030, 3);
      repeat (8) tick();
      check("no_stale_outputs", 0, out_cnt[0] - base, 1);
    end

    // random bubbles and backpressure, STAGES=2/8, both rounding modes
    run_random();

    for (int i = 0; i < NDUT; i++) check("queue_drained", i, exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
